// File: rtl/entry_defs.sv
// Shared definitions for the entry sequencer: FSM state encodings (which double
// as display-selector codes) and the default debounce length.
package entry_defs;

  // 10 ms at 27 MHz.
  localparam int unsigned DebounceCyclesDefault = 270000;

  // Counter width for the debouncer; covers the legal range 2..2^20-1.
  localparam int unsigned DebounceCntWidth = 20;

  typedef enum logic [1:0] {
    StEnterA  = 2'b00,
    StEnterB  = 2'b01,
    StEnterOp = 2'b10,
    StShow    = 2'b11
  } state_e;

  // Selector codes shown to the display; identical to the state encodings.
  localparam logic [1:0] SelEnterA  = 2'b00;
  localparam logic [1:0] SelEnterB  = 2'b01;
  localparam logic [1:0] SelEnterOp = 2'b10;
  localparam logic [1:0] SelShow    = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debouncer and rising-edge pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw bouncy button, asynchronous to clk
//   pulse      : registered single-cycle pulse, one per accepted press
module btn_debounce
  import entry_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam logic [DebounceCntWidth-1:0] CntMax = DebounceCntWidth'(DEBOUNCE_CYCLES - 1);

  logic                        sync1_q;
  logic                        sync2_q;
  logic                        level_q;
  logic                        level_d1_q;
  logic [DebounceCntWidth-1:0] cnt_q;
  logic                        pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      level_d1_q <= 1'b0;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      // Count consecutive samples that disagree with the accepted level; any
      // agreeing sample restarts the count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      level_d1_q <= level_q;
      // Pulse lands the cycle after the debounced level rises; falls are ignored.
      pulse_q    <= level_q & ~level_d1_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/entry_sequencer.sv
// Operand/opcode entry sequencer: steps through A, B, opcode entry and a result
// display state on debounced "next" presses; "clear" restarts entry.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   btn_next, btn_clr : raw bouncy buttons
//   sw                : operand/opcode switches
//   A, B              : registered operands
//   opCodeA           : registered ALU opcode
//   select            : current state code for the display
//   result_valid      : high only while showing the result
module entry_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = entry_defs::DebounceCyclesDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_clr,
  input  logic [3:0] sw,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] opCodeA,
  output logic [1:0] select,
  output logic       result_valid
);
  import entry_defs::*;

  logic next_pulse;
  logic clr_pulse;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_next),
    .pulse(next_pulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_clr),
    .pulse(clr_pulse)
  );

  state_e     state_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [2:0] op_q;
  logic       valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEnterA;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      op_q    <= 3'h0;
      valid_q <= 1'b0;
    end else if (clr_pulse) begin
      // Clear beats a simultaneous next.
      state_q <= StEnterA;
      a_q     <= sw;
      b_q     <= 4'h0;
      op_q    <= 3'h0;
      valid_q <= 1'b0;
    end else begin
      // The active register keeps loading in the pulse cycle, so the value
      // present at the press is the one frozen.
      unique case (state_q)
        StEnterA: begin
          a_q <= sw;
          if (next_pulse) state_q <= StEnterB;
        end
        StEnterB: begin
          b_q <= sw;
          if (next_pulse) state_q <= StEnterOp;
        end
        StEnterOp: begin
          op_q <= sw[2:0];
          if (next_pulse) begin
            state_q <= StShow;
            valid_q <= 1'b1;
          end
        end
        StShow: begin
          if (next_pulse) begin
            state_q <= StEnterA;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StEnterA;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign A            = a_q;
  assign B            = b_q;
  assign opCodeA      = op_q;
  assign select       = state_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_entry_sequencer.sv
module tb_entry_sequencer;

  logic       clk;
  logic       rst_n;
  logic       btn_next;
  logic       btn_clr;
  logic [3:0] sw;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] opCodeA;
  logic [1:0] select;
  logic       result_valid;

  int unsigned n_checks;
  int unsigned n_errors;

  entry_sequencer #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_next    (btn_next),
    .btn_clr     (btn_clr),
    .sw          (sw),
    .A           (A),
    .B           (B),
    .opCodeA     (opCodeA),
    .select      (select),
    .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean press: pulse after 7 edges, state update on the 8th; then release
  // and let the debounced level fall back.
  task automatic press_next();
    btn_next = 1'b1;
    tick(10);
    btn_next = 1'b0;
    tick(8);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    sw       = 4'h5;
    tick(3);

    // Reset state
    check("rst_A", A, 4'h0);
    check("rst_B", B, 4'h0);
    check("rst_op", opCodeA, 3'h0);
    check("rst_sel", select, 2'b00);
    check("rst_valid", result_valid, 1'b0);

    rst_n = 1'b1;
    tick(1);
    check("enterA_load", A, 4'h5);

    // Full entry sequence
    press_next();
    check("seq_sel_B", select, 2'b01);
    check("seq_A", A, 4'h5);
    sw = 4'hA;
    press_next();
    check("seq_sel_op", select, 2'b10);
    check("seq_B", B, 4'hA);
    sw = 4'hE;
    press_next();
    check("show_sel", select, 2'b11);
    check("show_valid", result_valid, 1'b1);
    check("show_A", A, 4'h5);
    check("show_B", B, 4'hA);
    check("show_op", opCodeA, 3'h6);

    // SHOW holds everything, then wraps to ENTER_A
    sw = 4'h3;
    tick(3);
    check("hold_A", A, 4'h5);
    check("hold_B", B, 4'hA);
    check("hold_op", opCodeA, 3'h6);
    press_next();
    check("wrap_sel", select, 2'b00);
    check("wrap_valid", result_valid, 1'b0);
    check("wrap_A", A, 4'h3);
    check("wrap_B", B, 4'hA);
    check("wrap_op", opCodeA, 3'h6);

    // Bounces shorter than the debounce length
    btn_next = 1'b1; tick(3);
    btn_next = 1'b0; tick(1);
    btn_next = 1'b1; tick(3);
    btn_next = 1'b0; tick(10);
    check("bounce_sel", select, 2'b00);

    // Held press: exact latency and a single pulse
    btn_next = 1'b1;
    tick(7);
    check("lat_before", select, 2'b00);
    tick(1);
    check("lat_at", select, 2'b01);
    tick(2);
    btn_next = 1'b0;
    tick(10);
    check("single_pulse", select, 2'b01);

    // Next and clear together in ENTER_OP: clear wins
    sw = 4'h3;
    press_next();
    check("pre_clr_sel", select, 2'b10);
    check("pre_clr_B", B, 4'h3);
    sw = 4'h5;
    tick(1);
    check("pre_clr_op", opCodeA, 3'h5);
    btn_next = 1'b1;
    btn_clr  = 1'b1;
    tick(7);
    check("clr_before", select, 2'b10);
    tick(1);
    check("clr_sel", select, 2'b00);
    check("clr_B", B, 4'h0);
    check("clr_op", opCodeA, 3'h0);
    tick(1);
    check("clr_A", A, 4'h5);
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    tick(10);
    check("clr_settle", select, 2'b00);

    // Asynchronous reset mid-ENTER_B with next held
    sw = 4'h9;
    press_next();
    check("rstmid_sel", select, 2'b01);
    btn_next = 1'b1;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sel", select, 2'b00);
    check("async_A", A, 4'h0);
    check("async_B", B, 4'h0);
    tick(2);
    rst_n = 1'b1;
    tick(7);
    check("post_rst_before", select, 2'b00);
    tick(1);
    check("post_rst_sel", select, 2'b01);
    check("post_rst_A", A, 4'h9);
    btn_next = 1'b0;
    tick(10);
    check("post_rst_settle", select, 2'b01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/entry_sequencer.md
ENTRY_SEQUENCER -- requirements
Module: entry_sequencer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 270000 (10 ms at 27 MHz), the number of consecutive stable synchronized samples needed to accept a button level change; legal range 2..2^20-1.
REQ-002 Port: clk  input  1  the single clock; all flops are clocked on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: btn_next  input  1  raw "next" button, active-high, asynchronous to clk, bouncy.
REQ-005 Port: btn_clr  input  1  raw "clear" button, active-high, asynchronous to clk, bouncy.
REQ-006 Port: sw  input  4  operand/opcode switch value; quasi-static.
REQ-007 Port: A  output  4  registered operand A to the datapath.
REQ-008 Port: B  output  4  registered operand B to the datapath.
REQ-009 Port: opCodeA  output  3  registered ALU opcode.
REQ-010 Port: select  output  2  display-selector code; equals the current state encoding.
REQ-011 Port: result_valid  output  1  high only in state SHOW.

Function
REQ-012 FSM states and encodings SHALL be ENTER_A=00, ENTER_B=01, ENTER_OP=10, SHOW=11; select SHALL be driven directly from the state register.
REQ-013 ENTER_A: A SHALL load sw every cycle; B and opCodeA SHALL hold.
REQ-014 ENTER_B: B SHALL load sw every cycle; A and opCodeA SHALL hold.
REQ-015 ENTER_OP: opCodeA SHALL load sw[2:0] every cycle; sw[3] SHALL be ignored; A and B SHALL hold.
REQ-016 SHOW: A, B and opCodeA SHALL all hold.
REQ-017 A next_pulse SHALL advance the FSM in the order ENTER_A -> ENTER_B -> ENTER_OP -> SHOW -> ENTER_A (wrap-around); in the pulse cycle the current register SHALL still load sw, so the value present at the pulse is the value frozen.
REQ-018 A clr_pulse in any state SHALL, on the next edge, set the state to ENTER_A and clear B and opCodeA to 0; A SHALL load sw, as it does in ENTER_A.
REQ-019 If next_pulse and clr_pulse occur in the same cycle, clr SHALL win and next SHALL be discarded.
REQ-020 Each button SHALL pass through a 2-flop synchronizer; a debounced level SHALL toggle only after DEBOUNCE_CYCLES consecutive synchronized samples differing from it, and the counter SHALL clear on any sample equal to the debounced level.
REQ-021 A pulse SHALL be a registered, single-cycle high, asserted the cycle after the debounced level rises; releasing the button SHALL produce no pulse.
REQ-022 Latency: for a clean raw rising edge sampled at edge N, the pulse SHALL be high in cycle N+2+DEBOUNCE_CYCLES, and the FSM/register update SHALL occur at the following edge.
REQ-023 A held button SHALL yield exactly one pulse; bounces shorter than DEBOUNCE_CYCLES SHALL yield none.

Reset
REQ-024 While rst_n=0: state=ENTER_A, A=B=0, opCodeA=0, select=00, result_valid=0, synchronizers, debounced levels, counters and pulses all 0.
REQ-025 Reset mid-entry or mid-debounce SHALL discard all progress; a button held across reset release SHALL generate one pulse DEBOUNCE_CYCLES+2 cycles after release.

Structure
REQ-026 State encodings and select codes SHALL reside in the shared package entry_defs, together with the DEBOUNCE_CYCLES default.
REQ-027 Synchronizer, debouncer and pulse generation SHALL form one sub-module, btn_debounce, instantiated once per button.
REQ-028 The block SHALL contain no combinational path from any input to any output.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Hold sw=0x5, press next; then sw=0xA, press next; then sw=0xE, press next -> A=5, B=A, opCodeA=6, select=11, result_valid=1.
REQ-030 In SHOW, change sw to 0x3 -> A, B and opCodeA unchanged; press next -> select=00 and A follows sw (=3) while B=A and opCodeA=6 hold.
REQ-031 Bounce btn_next high for 3 cycles, low for 1, high for 3, then low -> no pulse and state unchanged; hold it high for 10 cycles -> exactly one pulse, at cycle 6 after the first high sample.
REQ-032 Force next and clr to be debounced in the same cycle while in ENTER_OP -> state=ENTER_A, B=0, opCodeA=0.
REQ-033 Assert rst_n=0 asynchronously mid-ENTER_B while btn_next is held -> outputs are 0 immediately; after release, one pulse occurs at cycle 6, giving select=01.
